dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter that shares the single-ported data memory between the core load/store path (port 0) and a debug/loader port (port 1). It accepts one transaction at a time, drives the memory command, counts the fixed read latency and routes the response back to the owning requester. It sits between the core's memory stage and the data-memory array. Fairness is round-robin, and a blocked core sees `req_ready` low, which it uses as its stall.

## Interface
Parameters:
- `ADDR_W`, 32, address width (word-aligned; memory indexes `addr[7:2]`)
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, read latency in cycles from `mem_en` to valid `mem_rdata`; legal 1..4

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid[1:0]`  in  2  per-port request valid
- `req_we[1:0]`  in  2  per-port write enable (0 = read)
- `req_addr0`, `req_addr1`  in  ADDR_W  per-port address
- `req_wdata0`, `req_wdata1`  in  DATA_W  per-port write data
- `req_ready[1:0]`  out  2  per-port accept strobe
- `rsp_valid[1:0]`  out  2  per-port one-cycle completion pulse
- `rsp_rdata`  out  DATA_W  read data, shared by both ports, qualified by `rsp_valid`
- `mem_en`  out  1  memory command strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- FSM states: IDLE and RD_WAIT.
- **IDLE, arbitration.**
  - If exactly one `req_valid` is high, that port wins.
  - If both are high, the port not in `last_grant` wins.
  - The winner's `req_ready` is high in the same cycle. This is a combinational accept: the handshake completes when `req_valid & req_ready`.
- **Issue (in the accept cycle).**
  - `mem_en=1`; `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winner.
  - `last_grant` and `owner` are updated to the winner.
- **Write.** FSM stays in IDLE; `rsp_valid[owner]` pulses in the next cycle.
- **Read.** `cnt` is loaded with `MEM_LAT-1` and the FSM moves to RD_WAIT.
- **RD_WAIT.**
  - `req_ready=0` and `mem_en=0`.
  - If `cnt==0`: register `mem_rdata` into `rsp_rdata`, pulse `rsp_valid[owner]` in the next cycle, and go to IDLE.
  - Otherwise decrement `cnt`.
- **Other output behaviour.**
  - `rsp_rdata` holds its last value between reads; write completions do not change it.
  - Memory outputs are 0 whenever `mem_en=0`.
- **Requester rule.** A request with `req_valid` high and no `req_ready` may change or drop. The arbiter keeps no state for un-accepted requests.
- **Reset.**
  - Outputs: `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `mem_*=0`.
  - Internal: FSM=IDLE, `cnt=0`, `owner=0`, `last_grant=1`, so port 0 wins the first tie.
- **Reset mid-transaction.** An in-flight read is dropped and no `rsp_valid` is issued for it.

## Timing
- Let T be the accept cycle.
- **Write:** `rsp_valid` in T+1. A new accept is possible in T+1, giving 1 write per cycle sustained.
- **Read:** memory data is sampled in T+`MEM_LAT`; `rsp_valid` and `rsp_rdata` appear in T+`MEM_LAT`+1. The next accept is possible in T+`MEM_LAT`+1, giving 1 read per `MEM_LAT`+1 cycles.
- **Backpressure:** `req_ready` is low for both ports in every RD_WAIT cycle.
- **Responses:** at most one `rsp_valid` bit is high per cycle.
- **Response/accept overlap:** a response pulse and a new accept may occur in the same cycle, on the same or different ports.
- **Fairness:** with both ports continuously requesting, grants alternate 0,1,0,1…. Neither port waits more than one transaction.

## Structure
- Package `dmem_arb_pkg`:
  - state enum {IDLE, RD_WAIT}
  - port-id constants `PORT_CORE=0`, `PORT_DBG=1`
  - `MEM_LAT` legality bounds
- Sub-module `rr_arb2`: holds `last_grant` and produces a one-hot grant from `req_valid` plus an `advance` strobe.
- Top level holds the FSM, counter, owner register, muxes and response register.

## Test plan
- **Single write then read, `MEM_LAT`=1.**
  - Stimulus: port 0 writes 0xDEADBEEF at address 0x10 in cycle 0, then reads 0x10.
  - Response: write `rsp_valid[0]` in cycle 1; read accepted in cycle 1; `rsp_valid[0]` in cycle 3 with `rsp_rdata`=0xDEADBEEF.
- **Tie after reset.**
  - Stimulus: both ports assert a read in cycle 0.
  - Response: port 0 is granted in cycle 0; port 1 is granted in cycle 2; each `rsp_valid` goes only to its owner.
- **Continuous contention with writes.**
  - Stimulus: both ports write every cycle for 8 cycles.
  - Response: grants alternate 0,1,0,1…; exactly 8 `mem_en` pulses.
- **`MEM_LAT`=3 read.**
  - Stimulus: port 1 reads in cycle 0.
  - Response: `req_ready`=00 in cycles 1–3; `mem_rdata` sampled in cycle 3; `rsp_valid[1]` in cycle 4.
- **Reset mid-read.**
  - Stimulus: `MEM_LAT`=3, read accepted in cycle 0, `reset` pulsed in cycle 2.
  - Response: no `rsp_valid` is issued; all outputs are 0; a tie in the next request goes to port 0.
- **Withdrawn request.**
  - Stimulus: port 1 asserts `req_valid` during port 0's RD_WAIT, then drops it before IDLE.
  - Response: no grant and no `mem_en` for port 1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Port numbering, FSM encoding and read-latency limits live here.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  // Wide enough to hold MEM_LAT_MAX-1.
  localparam int CNT_W       = 2;

  function automatic logic [1:0] port_onehot(input logic port);
    return {port, ~port};
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant generator; remembers the last winner and
// flips priority whenever a grant is consumed (advance).
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == PORT_DBG) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_DBG;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the core (port 0) and the
// debug/loader port (port 1); one transaction in flight, fixed read latency.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("dmem_port_arbiter: MEM_LAT must be within 1..4");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [1:0]       rsp_valid_d;
  logic             load_rdata;
  logic [1:0]       grant;
  logic             accept;
  logic             win_port;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .advance   (accept),
    .grant     (grant)
  );

  // Accept is combinational and suppressed while reset is held so all outputs read 0.
  assign req_ready = (state_q == IDLE && !reset) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign win_port  = req_ready[1];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (accept) begin
      mem_en    = 1'b1;
      mem_we    = req_we[win_port];
      mem_addr  = win_port ? req_addr1  : req_addr0;
      mem_wdata = win_port ? req_wdata1 : req_wdata0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    rsp_valid_d = 2'b00;
    load_rdata  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = win_port;
          if (mem_we) begin
            rsp_valid_d = port_onehot(win_port);
          end else begin
            cnt_d   = CNT_W'(MEM_LAT - 1);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = port_onehot(owner_q);
          load_rdata  = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= PORT_CORE;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      rsp_valid <= rsp_valid_d;
      if (load_rdata) begin
        rsp_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench: two arbiters (MEM_LAT 1 and 3) share one random/directed
// stimulus stream; a transaction-level model predicts commands and responses.
module tb_dmem_port_arbiter;

  typedef struct {
    int          cyc;
    logic [1:0]  ready;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic        port;
    logic        is_read;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_we;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;

  logic [1:0]  req_ready [2];
  logic [1:0]  rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  int cyc;
  int n_checks;
  int n_fail;

  cmd_t cmd_q0[$], cmd_q1[$];
  rsp_t rsp_q0[$], rsp_q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Memory array per DUT with a read pipeline of the matching latency; cleared on reset.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] emem [64];
    logic [31:0] pipe [4];
    always @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < 64; k++) emem[k] <= '0;
        for (int k = 0; k < 4; k++) pipe[k] <= '0;
      end else begin
        if (mem_en[g] && mem_we[g]) emem[mem_addr[g][7:2]] <= mem_wdata[g];
        if (mem_en[g] && !mem_we[g]) pipe[0] <= emem[mem_addr[g][7:2]];
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign mem_rdata[g] = pipe[L-1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit pop_cmd(input int i, output cmd_t c);
    pop_cmd = 1'b0;
    c = '{cyc: -1, ready: 2'b00, en: 1'b0, we: 1'b0, addr: '0, wdata: '0};
    if (i == 0 && cmd_q0.size() > 0 && cmd_q0[0].cyc == cyc) begin
      c = cmd_q0.pop_front();
      pop_cmd = 1'b1;
    end else if (i == 1 && cmd_q1.size() > 0 && cmd_q1[0].cyc == cyc) begin
      c = cmd_q1.pop_front();
      pop_cmd = 1'b1;
    end
  endfunction

  function automatic bit pop_rsp(input int i, output rsp_t r);
    pop_rsp = 1'b0;
    r = '{cyc: -1, port: 1'b0, is_read: 1'b0, data: '0};
    if (i == 0 && rsp_q0.size() > 0 && rsp_q0[0].cyc == cyc) begin
      r = rsp_q0.pop_front();
      pop_rsp = 1'b1;
    end else if (i == 1 && rsp_q1.size() > 0 && rsp_q1[0].cyc == cyc) begin
      r = rsp_q1.pop_front();
      pop_rsp = 1'b1;
    end
  endfunction

  // Monitor: compares every DUT output mid-cycle against what the model queued.
  logic [31:0] exp_rdata [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cmd_t       c;
      rsp_t       r;
      logic [1:0] exp_rv;
      int         lat;
      lat = (i == 0) ? 1 : 3;
      if (pop_cmd(i, c)) begin
        check($sformatf("lat%0d req_ready", lat), {30'b0, req_ready[i]}, {30'b0, c.ready});
        check($sformatf("lat%0d mem_en", lat), {31'b0, mem_en[i]}, {31'b0, c.en});
        check($sformatf("lat%0d mem_we", lat), {31'b0, mem_we[i]}, {31'b0, c.we});
        check($sformatf("lat%0d mem_addr", lat), mem_addr[i], c.addr);
        check($sformatf("lat%0d mem_wdata", lat), mem_wdata[i], c.wdata);
      end
      exp_rv = 2'b00;
      if (reset) begin
        if (i == 0) rsp_q0.delete(); else rsp_q1.delete();
        exp_rdata[i] = '0;
      end else if (pop_rsp(i, r)) begin
        exp_rv = r.port ? 2'b10 : 2'b01;
        if (r.is_read) exp_rdata[i] = r.data;
      end
      check($sformatf("lat%0d rsp_valid", lat), {30'b0, rsp_valid[i]}, {30'b0, exp_rv});
      check($sformatf("lat%0d rsp_rdata", lat), rsp_rdata[i], exp_rdata[i]);
    end
  end

  // Transaction-level model state, owned by the stimulus process.
  int          busy_until [2];
  logic        last_port  [2];
  logic [31:0] shadow     [2][64];

  task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] we,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    @(posedge clk);
    #1;
    reset = rst; req_valid = v; req_we = we;
    req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
    for (int i = 0; i < 2; i++) begin
      cmd_t c;
      rsp_t r;
      int   w;
      int   lat;
      lat = (i == 0) ? 1 : 3;
      c = '{cyc: cyc, ready: 2'b00, en: 1'b0, we: 1'b0, addr: '0, wdata: '0};
      w = -1;
      if (rst) begin
        last_port[i]  = 1'b1;
        busy_until[i] = 0;
        for (int k = 0; k < 64; k++) shadow[i][k] = '0;
      end else if (cyc >= busy_until[i]) begin
        if (v == 2'b11)  w = last_port[i] ? 0 : 1;
        else if (v[0])   w = 0;
        else if (v[1])   w = 1;
      end
      if (w >= 0) begin
        c.ready = (w == 1) ? 2'b10 : 2'b01;
        c.en    = 1'b1;
        c.we    = we[w];
        c.addr  = (w == 1) ? a1 : a0;
        c.wdata = (w == 1) ? d1 : d0;
        last_port[i] = (w == 1);
        r.port    = (w == 1);
        r.is_read = !we[w];
        if (we[w]) begin
          shadow[i][c.addr[7:2]] = c.wdata;
          r.data = '0;
          r.cyc  = cyc + 1;
        end else begin
          r.data = shadow[i][c.addr[7:2]];
          r.cyc  = cyc + lat + 1;
          busy_until[i] = cyc + lat + 1;
        end
        if (i == 0) rsp_q0.push_back(r); else rsp_q1.push_back(r);
      end
      if (i == 0) cmd_q0.push_back(c); else cmd_q1.push_back(c);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);

    // Port 0 write then read back.
    step(1'b0, 2'b01, 2'b01, 32'h10, '0, 32'hDEADBEEF, '0);
    step(1'b0, 2'b01, 2'b00, 32'h10, '0, '0, '0);
    idle(5);

    // Read tie straight after reset: port 0 first.
    step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    for (int k = 0; k < 6; k++) step(1'b0, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0);
    idle(5);

    // Continuous write contention.
    for (int k = 0; k < 8; k++)
      step(1'b0, 2'b11, 2'b11, rand_addr(), rand_addr(), $urandom(), $urandom());
    idle(2);

    // Single port 1 read.
    step(1'b0, 2'b10, 2'b00, '0, 32'h10, '0, '0);
    idle(5);

    // Reset in the middle of a read, then a tie.
    step(1'b0, 2'b01, 2'b00, 32'h10, '0, '0, '0);
    step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    step(1'b0, 2'b11, 2'b00, 32'h10, 32'h20, '0, '0);
    idle(5);

    // Port 1 request withdrawn while port 0 read is outstanding.
    step(1'b0, 2'b01, 2'b00, 32'h14, '0, '0, '0);
    step(1'b0, 2'b10, 2'b00, '0, 32'h18, '0, 32'h55AA55AA);
    step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    idle(5);

    // Random traffic with occasional resets.
    for (int k = 0; k < 500; k++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           rand_addr(), rand_addr(), $urandom(), $urandom());
    end
    idle(8);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
